// File: rtl/memory_pkg.sv
// Shared encodings for the wait-state memory: FSM states, latched operation and the
// wait-counter ceiling.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int unsigned MAX_WAIT_STATES = 15;

endpackage

// File: rtl/memory_array.sv
// Synchronous single-port RAM: registered read, write on the same edge. Storage only;
// contents are never reset.
module memory_array #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned WIDTH         = 8
) (
  input  logic                     clock,
  input  logic                     writeEnable,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [WIDTH-1:0]         writeData,
  output logic [WIDTH-1:0]         readData
);

  logic [WIDTH-1:0] mem [0:(1 << ADDRESS_WIDTH)-1];

  always_ff @(posedge clock) begin
    if (writeEnable) begin
      mem[address] <= writeData;
    end
    readData <= mem[address];
  end

endmodule

// File: rtl/memory_wait_state.sv
// Single-port memory with read/write requests, tri-state data bus and programmable wait
// states. Optional even-parity storage and checking when MEMORY_PARITY_EN is defined.
module memory_wait_state
  import memory_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned WAIT_STATES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0]    data,
  input  logic                     readRequest,
  input  logic                     writeRequest,
  output logic                     ready,
  output logic                     busy
`ifdef MEMORY_PARITY_EN
  ,
  output logic                     parityError
`endif
);

`ifdef MEMORY_PARITY_EN
  localparam int unsigned MEM_WIDTH = DATA_WIDTH + 1;
`else
  localparam int unsigned MEM_WIDTH = DATA_WIDTH;
`endif
  localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_STATES);

  if (WAIT_STATES > MAX_WAIT_STATES) begin : g_wait_states_range
    $error("WAIT_STATES must not exceed %0d", MAX_WAIT_STATES);
  end

  state_t                   state;
  op_t                      op;
  logic [3:0]               wait_count;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;

  logic                     request;
  op_t                      req_op;
  logic                     enter_access;
  op_t                      mem_op;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_we;
  logic [MEM_WIDTH-1:0]     write_word;
  logic [MEM_WIDTH-1:0]     read_word;
  logic                     bus_drive;

  assign request = readRequest | writeRequest;
  assign req_op  = writeRequest ? OP_WRITE : OP_READ;

  // With zero wait states the array is accessed on the capture edge itself, so the
  // live request inputs bypass the latches.
  always_comb begin
    enter_access = 1'b0;
    mem_op       = op;
    mem_addr     = addr_q;
    mem_wdata    = data_q;
    case (state)
      IDLE: begin
        if (request && (WAIT_LIMIT == 4'd0)) begin
          enter_access = 1'b1;
          mem_op       = req_op;
          mem_addr     = address;
          mem_wdata    = data;
        end
      end
      WAIT: begin
        if ((wait_count + 4'd1) == WAIT_LIMIT) begin
          enter_access = 1'b1;
        end
      end
      default: begin
        enter_access = 1'b0;
      end
    endcase
  end

  assign mem_we = enter_access && (mem_op == OP_WRITE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      op         <= OP_READ;
      wait_count <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            addr_q     <= address;
            data_q     <= data;
            op         <= req_op;
            wait_count <= '0;
            busy       <= 1'b1;
            if (enter_access) begin
              state <= ACCESS;
              ready <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          wait_count <= wait_count + 4'd1;
          if (enter_access) begin
            state <= ACCESS;
            ready <= 1'b1;
          end
        end
        ACCESS: begin
          state      <= IDLE;
          busy       <= 1'b0;
          wait_count <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEMORY_PARITY_EN
  assign write_word  = {^mem_wdata, mem_wdata};
  assign parityError = bus_drive && (read_word[DATA_WIDTH] != ^read_word[DATA_WIDTH-1:0]);
`else
  assign write_word  = mem_wdata;
`endif

  memory_array #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .WIDTH        (MEM_WIDTH)
  ) u_array (
    .clock      (clock),
    .writeEnable(mem_we),
    .address    (mem_addr),
    .writeData  (write_word),
    .readData   (read_word)
  );

  assign bus_drive = (state == ACCESS) && (op == OP_READ);
  assign data      = bus_drive ? read_word[DATA_WIDTH-1:0] : 'z;

endmodule
